hpm_ctrl: RTL and testbench

HPM_CTRL -- requirements
Module: hpm_ctrl

---
 rtl/hpm_ctrl.sv | 128 ++++++++++++
 tb/tb_hpm_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpm_ctrl.sv
// Hardware performance monitor for an FPro MMIO slot: cycle, instruction and
// memory read/write event counters with a start/stop/one-shot window FSM.
module hpm_ctrl #(
  parameter int unsigned CW = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        write,
  input  logic        read,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        probe_inst,
  input  logic        probe_mem_rd,
  input  logic        probe_mem_wr,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_BAD  = 2'd3
  } state_e;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [CW-1:0] window_q, window_d;
  logic          oneshot_q, oneshot_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic       ctrl_wr, win_wr, start, stop, clear, count_en, reached;
  logic [3:0] ev;
  logic       unused_ok;

  assign ctrl_wr  = cs && write && (addr == 5'd0);
  assign win_wr   = cs && write && (addr == 5'd1);
  assign start    = ctrl_wr && wr_data[0] && !wr_data[1];
  assign stop     = ctrl_wr && wr_data[1];
  assign clear    = ctrl_wr && wr_data[2];
  assign count_en = (state_q == S_RUN) && !clear;
  // index order matches the counter register order: CYC, INST, RD, WR
  assign ev       = {probe_mem_wr, probe_mem_rd, probe_inst, 1'b1};
  // cycle counter must actually advance onto WINDOW; a saturated counter never "reaches"
  assign reached  = count_en && oneshot_q && (window_q != '0) &&
                    (cnt_q[0] != '1) && ((cnt_q[0] + ONE) == window_q);
  assign busy     = (state_q == S_RUN);
  assign unused_ok = ^{read, wr_data};

  always_comb begin
    state_d   = state_q;
    oneshot_d = oneshot_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    window_d  = win_wr ? wr_data[CW-1:0] : window_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (count_en && ev[i]) begin
        if (cnt_q[i] == '1) ovf_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] + ONE;
      end
    end
    if (clear) begin
      for (int unsigned i = 0; i < 4; i++) cnt_d[i] = '0;
      done_d = 1'b0;
      ovf_d  = 1'b0;
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d   = S_RUN;
          oneshot_d = wr_data[3];
          done_d    = 1'b0;
          ovf_d     = 1'b0;
          for (int unsigned i = 0; i < 4; i++) cnt_d[i] = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (reached) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      window_q  <= '0;
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      oneshot_q <= oneshot_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd1:    rd_data = 32'(window_q);
      5'd2:    rd_data = {28'd0, ovf_q, done_q, state_q};
      5'd3:    rd_data = 32'(cnt_q[0]);
      5'd4:    rd_data = 32'(cnt_q[1]);
      5'd5:    rd_data = 32'(cnt_q[2]);
      5'd6:    rd_data = 32'(cnt_q[3]);
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_hpm_ctrl.sv
// Bench for hpm_ctrl: a CW=32 and a CW=8 instance share stimulus; a rule-level
// model predicts every register and busy each cycle, plus literal spot checks.
module tb_hpm_ctrl;

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_DONE = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs = 1'b0, write = 1'b0, read = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic        pi = 1'b0, pr = 1'b0, pw = 1'b0;
  logic [31:0] rd0, rd1;
  logic        busy0, busy1;

  always #5 clk = ~clk;

  hpm_ctrl u_dut32 (
    .clk(clk), .reset_n(reset_n), .cs(cs), .write(write), .read(read),
    .addr(addr), .wr_data(wr_data), .rd_data(rd0),
    .probe_inst(pi), .probe_mem_rd(pr), .probe_mem_wr(pw), .busy(busy0)
  );

  hpm_ctrl #(.CW(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .cs(cs), .write(write), .read(read),
    .addr(addr), .wr_data(wr_data), .rd_data(rd1),
    .probe_inst(pi), .probe_mem_rd(pr), .probe_mem_wr(pw), .busy(busy1)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int          pm [3] = '{0, 0, 0};
  bit          scan = 1'b0;
  logic [4:0]  scan_tab [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd31};

  // model: k=0 is the 32-bit instance, k=1 the 8-bit one
  int              m_st  [2];
  longint unsigned m_cnt [2][4];
  longint unsigned m_win [2];
  longint unsigned m_max [2] = '{64'hFFFF_FFFF, 64'd255};
  bit              m_os [2], m_dn [2], m_ov [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = ST_IDLE; m_win[k] = 0; m_os[k] = 0; m_dn[k] = 0; m_ov[k] = 0;
      for (int j = 0; j < 4; j++) m_cnt[k][j] = 0;
    end
  endtask

  task automatic model_step();
    bit ctrl, wwin, start, stop, clear, moved, reached;
    bit hit [4];
    ctrl  = cs && write && (addr == 5'd0);
    wwin  = cs && write && (addr == 5'd1);
    start = ctrl && wr_data[0];
    stop  = ctrl && wr_data[1];
    clear = ctrl && wr_data[2];
    hit   = '{1'b1, pi, pr, pw};
    for (int k = 0; k < 2; k++) begin
      moved = 0; reached = 0;
      if (m_st[k] == ST_RUN && !clear) begin
        for (int j = 0; j < 4; j++)
          if (hit[j]) begin
            if (m_cnt[k][j] == m_max[k]) m_ov[k] = 1;
            else begin
              m_cnt[k][j] = m_cnt[k][j] + 64'd1;
              if (j == 0) moved = 1;
            end
          end
        reached = m_os[k] && m_win[k] != 0 && moved && m_cnt[k][0] == m_win[k];
      end
      if (clear) begin
        for (int j = 0; j < 4; j++) m_cnt[k][j] = 0;
        m_dn[k] = 0; m_ov[k] = 0;
      end
      if (stop) begin
        m_st[k] = ST_IDLE;
      end else if (start && m_st[k] != ST_RUN) begin
        m_st[k] = ST_RUN; m_os[k] = wr_data[3]; m_dn[k] = 0; m_ov[k] = 0;
        for (int j = 0; j < 4; j++) m_cnt[k][j] = 0;
      end else if (reached) begin
        m_st[k] = ST_DONE; m_dn[k] = 1;
      end
      if (wwin) m_win[k] = {32'd0, wr_data} & m_max[k];
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
    case (a)
      5'd1: return 32'(m_win[k]);
      5'd2: return 32'(m_st[k]) | (m_dn[k] ? 32'd4 : 32'd0) | (m_ov[k] ? 32'd8 : 32'd0);
      5'd3: return 32'(m_cnt[k][0]);
      5'd4: return 32'(m_cnt[k][1]);
      5'd5: return 32'(m_cnt[k][2]);
      5'd6: return 32'(m_cnt[k][3]);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%08h, want 0x%08h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk($sformatf("rd32[a=%0d]", addr), rd0, exp_rd(0, addr));
    chk($sformatf("rd8[a=%0d]", addr), rd1, exp_rd(1, addr));
    chk("busy32", 32'(busy0), 32'(m_st[0] == ST_RUN));
    chk("busy8", 32'(busy1), 32'(m_st[1] == ST_RUN));
  end

  function automatic logic pval(int mode);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return cyc[0];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    pi = pval(pm[0]); pr = pval(pm[1]); pw = pval(pm[2]);
    read = scan;
    if (scan) addr = scan_tab[cyc % 9];
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wr(logic [4:0] a, logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    tick();
    cs = 1'b0; write = 1'b0;
  endtask

  // at most four of these between ticks so the #1 steps stay before the next posedge
  task automatic expect_rd(int k, logic [4:0] a, logic [31:0] exp, string nm);
    addr = a;
    #1;
    chk(nm, (k == 0) ? rd0 : rd1, exp);
  endtask

  task automatic wait_idle(int maxc, string nm);
    int i = 0;
    while (busy0 && i < maxc) begin tick(); i++; end
    n_chk++;
    if (busy0) begin
      n_fail++;
      $display("FAIL timeout %s: busy still 1 after %0d cycles, want 0", nm, maxc);
    end
  endtask

  typedef struct { logic [4:0] a; logic [31:0] d; int gap; } vec_t;
  vec_t tab [10] = '{
    '{5'd1, 32'd7, 0}, '{5'd0, 32'd9, 10}, '{5'd0, 32'd1, 5}, '{5'd0, 32'd5, 20},
    '{5'd0, 32'd4, 3}, '{5'd1, 32'd2, 3}, '{5'd0, 32'd2, 4}, '{5'd0, 32'd6, 8},
    '{5'd0, 32'd12, 30}, '{5'd0, 32'd2, 2}
  };

  initial begin
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    tick();
    expect_rd(0, 5'd2, 32'd0, "status_after_reset");
    expect_rd(0, 5'd3, 32'd0, "cyc_after_reset");
    chk("busy_after_reset", 32'(busy0), 32'd0);

    // one-shot window of 100 with instruction probe every other cycle
    tick();
    wr(5'd1, 32'd100);
    pm[0] = 2;
    wr(5'd0, 32'h9);
    wait_idle(150, "oneshot100");
    pm[0] = 0;
    expect_rd(0, 5'd3, 32'd100, "oneshot_cyc");
    expect_rd(0, 5'd4, 32'd50,  "oneshot_inst");
    expect_rd(0, 5'd2, 32'h6,   "oneshot_status");
    chk("oneshot_busy", 32'(busy0), 32'd0);
    tick();
    expect_rd(1, 5'd3, 32'd100, "oneshot_cyc_cw8");

    // start, stop 37 cycles later, write probe held high
    tick();
    pm[2] = 1;
    wr(5'd0, 32'h1);
    idle(36);
    wr(5'd0, 32'h2);
    pm[2] = 0;
    expect_rd(0, 5'd3, 32'd37, "stop37_cyc");
    expect_rd(0, 5'd6, 32'd37, "stop37_wr");
    expect_rd(0, 5'd2, 32'd0,  "stop37_status");
    expect_rd(0, 5'd1, 32'd100, "window_readback");

    // free run 300 cycles: 8-bit instance saturates
    tick();
    wr(5'd0, 32'h1);
    idle(300);
    wr(5'd0, 32'h2);
    expect_rd(1, 5'd3, 32'd255, "sat_cyc_cw8");
    expect_rd(1, 5'd2, 32'h8,   "sat_status_cw8");
    expect_rd(0, 5'd3, 32'd301, "free_cyc_cw32");
    tick();
    wr(5'd0, 32'h4);
    expect_rd(1, 5'd3, 32'd0, "clear_cyc_cw8");
    expect_rd(1, 5'd2, 32'd0, "clear_status_cw8");

    // conflicts: STOP beats START; CLEAR+START from DONE
    tick();
    wr(5'd0, 32'h3);
    expect_rd(0, 5'd2, 32'd0, "stopstart_idle");
    tick();
    wr(5'd1, 32'd10);
    wr(5'd0, 32'h9);
    wait_idle(30, "oneshot10");
    expect_rd(0, 5'd2, 32'h6, "done10_status");
    tick();
    wr(5'd0, 32'h5);
    expect_rd(0, 5'd3, 32'd0, "restart_cyc");
    expect_rd(0, 5'd2, 32'h1, "restart_status");
    chk("restart_busy", 32'(busy0), 32'd1);
    idle(5);
    wr(5'd0, 32'h3);
    expect_rd(0, 5'd2, 32'd0, "stop_run_status");
    expect_rd(0, 5'd3, 32'd6, "stop_run_cyc");

    // window lowered below the running count: no termination
    tick();
    wr(5'd1, 32'd20);
    wr(5'd0, 32'h8 | 32'h1);
    idle(9);
    wr(5'd1, 32'd5);
    idle(30);
    chk("low_window_busy", 32'(busy0), 32'd1);
    wr(5'd0, 32'h2);
    expect_rd(0, 5'd3, 32'd41, "low_window_cyc");

    // CLEAR in RUN restarts counting from zero
    wr(5'd0, 32'h1);
    idle(10);
    wr(5'd0, 32'h4);
    expect_rd(0, 5'd3, 32'd0, "clear_run_cyc0");
    tick();
    expect_rd(0, 5'd3, 32'd1, "clear_run_cyc1");
    tick();
    wr(5'd0, 32'h1);
    idle(3);
    wr(5'd0, 32'h2);
    expect_rd(0, 5'd3, 32'd7, "start_in_run_ignored");

    // one-shot with WINDOW 0 is unbounded
    wr(5'd1, 32'd0);
    wr(5'd0, 32'h9);
    idle(50);
    chk("window0_busy", 32'(busy0), 32'd1);
    wr(5'd0, 32'h2);

    // window width truncation and unmapped addresses
    wr(5'd1, 32'h0000_1234);
    wr(5'd9, 32'd5);
    expect_rd(0, 5'd1, 32'h1234, "window_cw32");
    expect_rd(1, 5'd1, 32'h34,   "window_cw8");
    expect_rd(0, 5'd7, 32'd0,    "addr7_zero");
    expect_rd(0, 5'd31, 32'd0,   "addr31_zero");

    // STOP from DONE keeps DONE
    tick();
    wr(5'd1, 32'd4);
    wr(5'd0, 32'h9);
    wait_idle(20, "oneshot4");
    wr(5'd0, 32'h2);
    expect_rd(0, 5'd2, 32'h4, "done_retained");
    expect_rd(0, 5'd3, 32'd4, "done_cyc4");

    // reset in the middle of a run
    tick();
    pm[0] = 1;
    wr(5'd0, 32'h1);
    idle(20);
    reset_n = 1'b0;
    expect_rd(0, 5'd3, 32'd0, "rst_run_cyc");
    expect_rd(0, 5'd4, 32'd0, "rst_run_inst");
    expect_rd(0, 5'd1, 32'd0, "rst_run_window");
    chk("rst_run_busy", 32'(busy0), 32'd0);
    tick();
    reset_n = 1'b1;
    idle(5);
    expect_rd(0, 5'd2, 32'd0, "post_reset_idle");
    tick();
    wr(5'd0, 32'h1);
    expect_rd(0, 5'd3, 32'd0, "post_reset_start");
    tick();
    expect_rd(0, 5'd3, 32'd1, "post_reset_cyc1");
    expect_rd(0, 5'd4, 32'd1, "post_reset_inst1");
    tick();
    wr(5'd0, 32'h2);

    // mixed sequence with random probes and scanning reads
    pm = '{3, 3, 3};
    scan = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr(tab[i].a, tab[i].d);
      idle(tab[i].gap);
    end
    scan = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
